// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack-style 4K-word memory subsystem:
// address/data widths, the block-copier state encoding and a length clamp helper.
package hack_mem_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int LEN_W     = 13;
    localparam int RAM_WORDS = 4096;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } copier_state_e;

    // Requested lengths beyond the memory size clamp to one full pass.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(RAM_WORDS)) ? LEN_W'(RAM_WORDS) : l;
    endfunction

endpackage

// File: rtl/ram_block_copier.sv
// Block copier that owns a single-port RAM4K-style port while busy, moving
// one word per READ/WRITE pair in ascending order with wraparound addressing.
module ram_block_copier
    import hack_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    copier_state_e     state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] data_buf_q, data_buf_d;
    logic [LEN_W-1:0]  len_sat;

    assign len_sat = sat_len(len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_buf_q  <= data_buf_d;
        end
    end

    // Pointers wrap naturally at the ADDR_W boundary, so copies may cross the top of memory.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        data_buf_d  = data_buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d   = src;
                    dst_ptr_d   = dst;
                    remaining_d = len_sat;
                    state_d     = (len_sat == '0) ? DONE : READ;
                end
            end
            READ: begin
                data_buf_d = mem_out;
                state_d    = WRITE;
            end
            WRITE: begin
                src_ptr_d   = src_ptr_q + ADDR_W'(1);
                dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - LEN_W'(1);
                state_d     = (remaining_q == LEN_W'(1)) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write enable is masked by reset so an aborting edge never commits a word.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        mem_address = '0;
        mem_in      = '0;
        mem_load    = 1'b0;
        case (state_q)
            READ: begin
                mem_address = src_ptr_q;
            end
            WRITE: begin
                mem_address = dst_ptr_q;
                mem_in      = data_buf_q;
                mem_load    = !reset;
            end
            default: begin
                mem_address = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier against a behavioural RAM4K with
// combinational read; each scenario task checks its own hand-computed results.
module tb_ram_block_copier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] src;
    logic [11:0] dst;
    logic [12:0] len;
    logic        busy;
    logic        done;
    logic [11:0] memAddress;
    logic [15:0] memIn;
    logic        memLoad;
    logic [15:0] memOut;

    logic [15:0] ram  [0:4095] = '{default: 16'h0000};
    logic [15:0] snap [0:4095];
    logic        pokeEn   = 1'b0;
    logic [11:0] pokeAddr = '0;
    logic [15:0] pokeData = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_block_copier dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_address (memAddress),
        .mem_in      (memIn),
        .mem_load    (memLoad),
        .mem_out     (memOut)
    );

    // RAM4K model: combinational read, write on the rising edge; backdoor preload shares the port.
    assign memOut = ram[memAddress];
    always @(posedge clk) begin
        if (memLoad)
            ram[memAddress] <= memIn;
        else if (pokeEn)
            ram[pokeAddr] <= pokeData;
    end

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(posedge clk);
        #1 pokeEn = 1'b0;
    endtask

    task automatic take_snapshot();
        for (int i = 0; i < 4096; i++) snap[i] = ram[i];
    endtask

    function automatic int count_diffs();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== snap[i]) n++;
        return n;
    endfunction

    task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input logic [12:0] l,
                            input int maxCycles, output int doneCycle, output int loadCount);
        doneCycle = -1;
        loadCount = 0;
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(posedge clk);
        for (int c = 1; c <= maxCycles; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (memLoad) loadCount++;
            if (done) begin
                doneCycle = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b want=0", done); end
        checks++; if (memLoad !== 1'b0) begin errors++; $display("[TB] FAIL reset_load got=%0b want=0", memLoad); end
        checks++; if (memAddress !== 12'd0) begin errors++; $display("[TB] FAIL reset_addr got=%0d want=0", memAddress); end
        checks++; if (memIn !== 16'h0) begin errors++; $display("[TB] FAIL reset_in got=%h want=0000", memIn); end
        reset = 1'b0;
    endtask

    task automatic test_basic_copy();
        int dc, lc;
        logic [15:0] expv [4];
        expv[0] = 16'h1111; expv[1] = 16'h2222; expv[2] = 16'h3333; expv[3] = 16'h4444;
        for (int i = 0; i < 4; i++) poke(12'(100 + i), expv[i]);
        poke(12'd99, 16'h0099);
        poke(12'd104, 16'h0104);
        poke(12'd199, 16'h0199);
        poke(12'd204, 16'h0204);
        run_copy(12'd100, 12'd200, 13'd4, 50, dc, lc);
        checks++; if (dc !== 9) begin errors++; $display("[TB] FAIL basic_done_cycle got=%0d want=9", dc); end
        checks++; if (lc !== 4) begin errors++; $display("[TB] FAIL basic_load_count got=%0d want=4", lc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_in_done got=%0b want=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after busy=%0b done=%0b want 0/0", busy, done); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[200 + i] !== expv[i]) begin errors++; $display("[TB] FAIL basic_word%0d got=%h want=%h", i, ram[200 + i], expv[i]); end
        end
        checks++; if (ram[99] !== 16'h0099) begin errors++; $display("[TB] FAIL basic_ram99 got=%h want=0099", ram[99]); end
        checks++; if (ram[104] !== 16'h0104) begin errors++; $display("[TB] FAIL basic_ram104 got=%h want=0104", ram[104]); end
        checks++; if (ram[199] !== 16'h0199) begin errors++; $display("[TB] FAIL basic_ram199 got=%h want=0199", ram[199]); end
        checks++; if (ram[204] !== 16'h0204) begin errors++; $display("[TB] FAIL basic_ram204 got=%h want=0204", ram[204]); end
    endtask

    task automatic test_zero_len();
        int dc, lc;
        poke(12'd5, 16'h5555);
        poke(12'd6, 16'h6666);
        take_snapshot();
        run_copy(12'd5, 12'd6, 13'd0, 20, dc, lc);
        checks++; if (dc !== 1) begin errors++; $display("[TB] FAIL zero_done_cycle got=%0d want=1", dc); end
        checks++; if (lc !== 0) begin errors++; $display("[TB] FAIL zero_load_count got=%0d want=0", lc); end
        @(negedge clk);
        checks++; if (count_diffs() !== 0) begin errors++; $display("[TB] FAIL zero_mem_changed got=%0d diffs want=0", count_diffs()); end
    endtask

    task automatic test_wrap();
        int dc, lc;
        logic [15:0] expv [4];
        expv[0] = 16'hAAAA; expv[1] = 16'hBBBB; expv[2] = 16'hCCCC; expv[3] = 16'hDDDD;
        poke(12'd4094, expv[0]);
        poke(12'd4095, expv[1]);
        poke(12'd0, expv[2]);
        poke(12'd1, expv[3]);
        run_copy(12'd4094, 12'd10, 13'd4, 50, dc, lc);
        checks++; if (dc !== 9) begin errors++; $display("[TB] FAIL wrap_src_done_cycle got=%0d want=9", dc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[10 + i] !== expv[i]) begin errors++; $display("[TB] FAIL wrap_src_word%0d got=%h want=%h", i, ram[10 + i], expv[i]); end
        end
        poke(12'd20, 16'h1234);
        poke(12'd21, 16'h5678);
        run_copy(12'd20, 12'd4095, 13'd2, 50, dc, lc);
        @(negedge clk);
        checks++; if (dc !== 5) begin errors++; $display("[TB] FAIL wrap_dst_done_cycle got=%0d want=5", dc); end
        checks++; if (ram[4095] !== 16'h1234) begin errors++; $display("[TB] FAIL wrap_dst_4095 got=%h want=1234", ram[4095]); end
        checks++; if (ram[0] !== 16'h5678) begin errors++; $display("[TB] FAIL wrap_dst_0 got=%h want=5678", ram[0]); end
        checks++; if (ram[1] !== 16'hDDDD) begin errors++; $display("[TB] FAIL wrap_dst_1 got=%h want=DDDD", ram[1]); end
    endtask

    task automatic test_reset_mid_copy();
        int sawDone = 0;
        for (int i = 0; i < 8; i++) poke(12'(300 + i), 16'(16'h3000 + i + 1));
        @(negedge clk);
        start = 1'b1;
        src   = 12'd300;
        dst   = 12'd400;
        len   = 13'd8;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) sawDone = 1;
        end
        @(negedge clk);
        checks++; if (memLoad !== 1'b1) begin errors++; $display("[TB] FAIL abort_third_write_active got=%0b want=1", memLoad); end
        reset = 1'b1;
        #1;
        checks++; if (memLoad !== 1'b0) begin errors++; $display("[TB] FAIL abort_load_gated got=%0b want=0", memLoad); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sawDone !== 0) begin errors++; $display("[TB] FAIL abort_status busy=%0b done=%0b early_done=%0d want 0/0/0", busy, done, sawDone); end
        checks++; if (memAddress !== 12'd0 || memIn !== 16'h0 || memLoad !== 1'b0) begin errors++; $display("[TB] FAIL abort_mem_outputs addr=%0d in=%h load=%0b want 0/0000/0", memAddress, memIn, memLoad); end
        checks++; if (ram[400] !== 16'h3001) begin errors++; $display("[TB] FAIL abort_word0 got=%h want=3001", ram[400]); end
        checks++; if (ram[401] !== 16'h3002) begin errors++; $display("[TB] FAIL abort_word1 got=%h want=3002", ram[401]); end
        checks++; if (ram[402] !== 16'h0000) begin errors++; $display("[TB] FAIL abort_word2 got=%h want=0000", ram[402]); end
        checks++; if (ram[403] !== 16'h0000) begin errors++; $display("[TB] FAIL abort_word3 got=%h want=0000", ram[403]); end
    endtask

    task automatic test_back_to_back();
        int dc = -1;
        int dc2 = -1;
        poke(12'd500, 16'h0A01);
        poke(12'd501, 16'h0A02);
        poke(12'd502, 16'h0A03);
        poke(12'd700, 16'h7777);
        @(negedge clk);
        start = 1'b1;
        src   = 12'd500;
        dst   = 12'd600;
        len   = 13'd3;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2) begin
                start = 1'b1;
                src   = 12'd700;
                dst   = 12'd800;
                len   = 13'd1;
            end
            if (done) begin
                dc    = c;
                start = 1'b1;
                src   = 12'd700;
                dst   = 12'd900;
                len   = 13'd1;
                break;
            end
        end
        checks++; if (dc !== 7) begin errors++; $display("[TB] FAIL b2b_first_done_cycle got=%0d want=7", dc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_after_done got=%0b want=0", busy); end
        start = 1'b1;
        src   = 12'd700;
        dst   = 12'd1000;
        len   = 13'd1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                dc2 = c;
                break;
            end
        end
        @(negedge clk);
        checks++; if (dc2 !== 3) begin errors++; $display("[TB] FAIL b2b_second_done_cycle got=%0d want=3", dc2); end
        checks++; if (ram[600] !== 16'h0A01 || ram[601] !== 16'h0A02 || ram[602] !== 16'h0A03) begin errors++; $display("[TB] FAIL b2b_first_copy got=%h %h %h want=0a01 0a02 0a03", ram[600], ram[601], ram[602]); end
        checks++; if (ram[800] !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_busy_start_ignored got=%h want=0000", ram[800]); end
        checks++; if (ram[900] !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_done_start_ignored got=%h want=0000", ram[900]); end
        checks++; if (ram[1000] !== 16'h7777) begin errors++; $display("[TB] FAIL b2b_idle_start_accepted got=%h want=7777", ram[1000]); end
    endtask

    task automatic test_saturate();
        int dc, lc;
        take_snapshot();
        run_copy(12'd0, 12'd0, 13'd5000, 9000, dc, lc);
        @(negedge clk);
        checks++; if (dc !== 8193) begin errors++; $display("[TB] FAIL sat_done_cycle got=%0d want=8193", dc); end
        checks++; if (lc !== 4096) begin errors++; $display("[TB] FAIL sat_load_count got=%0d want=4096", lc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL sat_idle_after got=%0b want=0", busy); end
        checks++; if (count_diffs() !== 0) begin errors++; $display("[TB] FAIL sat_mem_changed got=%0d diffs want=0", count_diffs()); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_wrap();
        test_reset_mid_copy();
        test_back_to_back();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_block_copier.md
# ram_block_copier

Memory-side initiator that drives a RAM4K-compatible port (address / in / load / out) to copy a block of words from a source range to a destination range in the same 4K-word space. It sits between a control source (CPU-visible start register or testbench) and the RAM4K instance, owning the RAM port while busy. Single-port RAM with combinational read means each word takes one read cycle plus one write cycle.

## Interface
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 16, data word width
- LEN_W, 13, length width; holds 0..4096
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  request; sampled only in IDLE
- src  in  ADDR_W  first source address, sampled with start
- dst  in  ADDR_W  first destination address, sampled with start
- len  in  LEN_W  word count, sampled with start; values >4096 saturate to 4096
- busy  out  1  high from cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse on completion
- mem_address  out  ADDR_W  to RAM address
- mem_in  out  DATA_W  to RAM in (write data)
- mem_load  out  1  to RAM load (write enable)
- mem_out  in  DATA_W  from RAM out; valid combinationally for current mem_address

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: busy=0, done=0, mem_load=0, mem_address=0, mem_in=0. On start=1: latch src, dst, saturated len into src_ptr, dst_ptr, remaining. remaining=0 -> DONE; else -> READ.
- READ: mem_address=src_ptr, mem_load=0. At edge capture mem_out into data_buf -> WRITE.
- WRITE: mem_address=dst_ptr, mem_in=data_buf, mem_load=1. At edge: src_ptr+1, dst_ptr+1, remaining-1; if remaining was 1 -> DONE else -> READ.
- DONE: done=1, busy=1, mem_load=0 -> IDLE.
- Pointer arithmetic modulo 2^ADDR_W: address 4095 +1 wraps to 0; copies crossing the top of memory continue at 0.
- Copy is always ascending. Overlapping ranges with dst in (src, src+len) propagate already-overwritten data; defined behaviour, caller's responsibility. dst==src rewrites identical data.
- start while busy (READ/WRITE/DONE) is ignored; no queueing. start in the same cycle as done pulse is ignored; next accepted start is in IDLE.
- len=4096 with dst==src copies every word once; no infinite loop.

## Timing
- Reset: at the reset edge state=IDLE, all registered outputs 0. mem_load is gated combinationally by !reset, so no RAM write occurs at an edge where reset=1, even if state was WRITE.
- Reset mid-copy aborts: words already written stay written, no done pulse.
- Start accepted at edge E0. Cycle 1 = first READ. For len=N>0: writes at edges ending cycles 2,4,...,2N; done high during cycle 2N+1; IDLE at cycle 2N+2.
- len=0: done high during cycle 1, no mem_load assertion.
- Read data assumed combinational (RAM4K-style); captured at end of READ cycle, no extra wait state.
- Throughput: 2 cycles/word + 1 DONE cycle per transfer.

## Structure
- Shared package hack_mem_pkg: ADDR_W=12, DATA_W=16, RAM_WORDS=4096, copier state enum (IDLE, READ, WRITE, DONE).
- Single flat module; no sub-module is natural. Testbench instantiates it against a RAM4K instance.

## Test plan
- Preload RAM[100..103]=0x1111,0x2222,0x3333,0x4444; start src=100 dst=200 len=4 -> RAM[200..203] match, done in cycle 9, mem_load high exactly 4 cycles, RAM[99],[104],[199],[204] unchanged.
- len=0, src=5 dst=6 -> done in cycle 1, mem_load never high, memory unchanged.
- Wrap: src=4094 dst=10 len=4 with RAM[4094]=0xAAAA,[4095]=0xBBBB,[0]=0xCCCC,[1]=0xDDDD -> RAM[10..13] = those values in order; also dst=4095 len=2 writes RAM[4095] and RAM[0].
- Reset asserted during the 3rd WRITE cycle of a len=8 copy -> exactly 2 destination words changed, the 3rd not written, busy=0 and done=0 next cycle, all mem outputs 0.
- start pulsed again during busy with different src/dst -> ignored; original copy completes unchanged; a start in the done cycle is ignored, one in the following IDLE cycle is accepted.
- len=5000 -> saturates to 4096: done in cycle 8193; src=0 dst=0 leaves memory unchanged.
